// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave backed by a word-indexed register memory.
// Independent write and read FSMs; out-of-range addresses complete with SLVERR.
module axi4_lite_slave #(
  parameter int Addr_Width = 32,
  parameter int Data_Width = 32,
  parameter int Mem_Depth  = 64
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [Addr_Width-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [Data_Width-1:0] WDATA,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [Addr_Width-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [Data_Width-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int IDX = $clog2(Mem_Depth);

  localparam logic [1:0] WR_IDLE      = 2'd0;
  localparam logic [1:0] WR_WAIT_DATA = 2'd1;
  localparam logic [1:0] WR_WAIT_ADDR = 2'd2;
  localparam logic [1:0] WR_RESP      = 2'd3;
  localparam logic [0:0] RD_IDLE      = 1'b0;
  localparam logic [0:0] RD_DATA      = 1'b1;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  logic [Data_Width-1:0] mem [Mem_Depth];

  logic [1:0]            wr_state_reg, wr_state_next;
  logic [0:0]            rd_state_reg, rd_state_next;
  logic                  aw_ready_reg, w_ready_reg, ar_ready_reg;
  logic                  bvalid_reg, rvalid_reg;
  logic [1:0]            bresp_reg, rresp_reg;
  logic [Data_Width-1:0] rdata_reg;
  logic [Addr_Width-1:0] awaddr_reg;
  logic [Data_Width-1:0] wdata_reg;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  commit_en;
  logic [Addr_Width-1:0] commit_addr;
  logic [Data_Width-1:0] commit_data;
  logic                  commit_in_range, ar_in_range;

  assign AWREADY = aw_ready_reg;
  assign WREADY  = w_ready_reg;
  assign ARREADY = ar_ready_reg;
  assign BVALID  = bvalid_reg;
  assign BRESP   = bresp_reg;
  assign RVALID  = rvalid_reg;
  assign RRESP   = rresp_reg;
  assign RDATA   = rdata_reg;

  // Handshakes use the registered readies, so VALID alone never latches anything.
  assign aw_hs = AWVALID && aw_ready_reg;
  assign w_hs  = WVALID && w_ready_reg;
  assign ar_hs = ARVALID && ar_ready_reg;

  assign commit_in_range = (commit_addr[Addr_Width-1:IDX] == '0);
  assign ar_in_range     = (ARADDR[Addr_Width-1:IDX] == '0);

  always_comb begin
    wr_state_next = wr_state_reg;
    commit_en     = 1'b0;
    commit_addr   = AWADDR;
    commit_data   = WDATA;
    case (wr_state_reg)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          commit_en     = 1'b1;
          wr_state_next = WR_RESP;
        end else if (aw_hs) begin
          wr_state_next = WR_WAIT_DATA;
        end else if (w_hs) begin
          wr_state_next = WR_WAIT_ADDR;
        end
      end
      WR_WAIT_DATA: begin
        if (w_hs) begin
          commit_en     = 1'b1;
          commit_addr   = awaddr_reg;
          wr_state_next = WR_RESP;
        end
      end
      WR_WAIT_ADDR: begin
        if (aw_hs) begin
          commit_en     = 1'b1;
          commit_data   = wdata_reg;
          wr_state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (BREADY) begin
          wr_state_next = WR_IDLE;
        end
      end
      default: wr_state_next = WR_IDLE;
    endcase
  end

  // Channel outputs are registered from the next state so readies stay low during reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_reg <= WR_IDLE;
      aw_ready_reg <= 1'b0;
      w_ready_reg  <= 1'b0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
      awaddr_reg   <= '0;
      wdata_reg    <= '0;
    end else begin
      wr_state_reg <= wr_state_next;
      aw_ready_reg <= (wr_state_next == WR_IDLE) || (wr_state_next == WR_WAIT_ADDR);
      w_ready_reg  <= (wr_state_next == WR_IDLE) || (wr_state_next == WR_WAIT_DATA);
      bvalid_reg   <= (wr_state_next == WR_RESP);
      if (aw_hs) begin
        awaddr_reg <= AWADDR;
      end
      if (w_hs) begin
        wdata_reg <= WDATA;
      end
      if (commit_en) begin
        bresp_reg <= commit_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < Mem_Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (commit_en && commit_in_range) begin
      mem[commit_addr[IDX-1:0]] <= commit_data;
    end
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      RD_IDLE: if (ar_hs) rd_state_next = RD_DATA;
      RD_DATA: if (RREADY) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  // A same-edge write to the read index is not yet visible here: read-before-write.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state_reg <= RD_IDLE;
      ar_ready_reg <= 1'b0;
      rvalid_reg   <= 1'b0;
      rresp_reg    <= RESP_OKAY;
      rdata_reg    <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      ar_ready_reg <= (rd_state_next == RD_IDLE);
      rvalid_reg   <= (rd_state_next == RD_DATA);
      if (ar_hs) begin
        rdata_reg <= ar_in_range ? mem[ARADDR[IDX-1:0]] : '0;
        rresp_reg <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Self-checking bench for axi4_lite_slave: vector table plus hand-written corner sequences,
// expected responses queued at drive time and popped when the response appears.
module tb_axi4_lite_slave;

  logic        clk = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } r_exp_t;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } vec_t;

  logic [1:0] b_q[$];
  r_exp_t     r_q[$];
  vec_t       vecs[11];

  axi4_lite_slave dut (
    .ACLK(clk), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge before the edge where the handshake happens.
  task automatic wait_ready(input logic need_aw, input logic need_w, input logic need_ar);
    int n = 0;
    while (!((!need_aw || AWREADY) && (!need_w || WREADY) && (!need_ar || ARREADY)) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: actual=ready low for 20 cycles required=ready high");
    end
  endtask

  task automatic pop_b(input string name);
    logic [1:0] e;
    if (b_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: actual=response with empty queue required=queued expectation", name);
    end else begin
      e = b_q.pop_front();
      check(name, {62'd0, BRESP}, {62'd0, e});
    end
  endtask

  task automatic pop_r(input string name);
    r_exp_t e;
    if (r_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: actual=response with empty queue required=queued expectation", name);
    end else begin
      e = r_q.pop_front();
      check(name, {30'd0, RRESP, RDATA}, {30'd0, e});
    end
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    AWADDR = addr; WDATA = data; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    b_q.push_back(resp);
    wait_ready(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0;
    check("b_latency", {63'd0, BVALID}, 64'd1);
    $display("WR addr=%08h data=%08h bresp=%b", addr, data, BRESP);
    pop_b("bresp");
    @(negedge clk);
    check("b_drop", {63'd0, BVALID}, 64'd0);
    check("aw_ready_back", {63'd0, AWREADY}, 64'd1);
  endtask

  task automatic read_word(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    r_q.push_back('{resp: resp, data: data});
    wait_ready(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    ARVALID = 1'b0;
    check("r_latency", {63'd0, RVALID}, 64'd1);
    $display("RD addr=%08h rdata=%08h rresp=%b", addr, RDATA, RRESP);
    pop_r("rdata_rresp");
    @(negedge clk);
    check("r_drop", {63'd0, RVALID}, 64'd0);
    check("ar_ready_back", {63'd0, ARREADY}, 64'd1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'd5,           32'hDEAD_BEEF, 2'b00};
    vecs[1]  = '{1'b0, 32'd5,           32'hDEAD_BEEF, 2'b00};
    vecs[2]  = '{1'b1, 32'd64,          32'h0000_FFFF, 2'b10};
    vecs[3]  = '{1'b0, 32'd64,          32'h0000_0000, 2'b10};
    vecs[4]  = '{1'b0, 32'd0,           32'h0000_0000, 2'b00};
    vecs[5]  = '{1'b1, 32'd63,          32'h1111_2222, 2'b00};
    vecs[6]  = '{1'b0, 32'd63,          32'h1111_2222, 2'b00};
    vecs[7]  = '{1'b1, 32'h8000_0005,   32'h0BAD_0BAD, 2'b10};
    vecs[8]  = '{1'b0, 32'd5,           32'hDEAD_BEEF, 2'b00};
    vecs[9]  = '{1'b1, 32'd0,           32'h0000_CAFE, 2'b00};
    vecs[10] = '{1'b0, 32'd0,           32'h0000_CAFE, 2'b00};

    ARESET = 1'b1;
    AWADDR = '0; WDATA = '0; ARADDR = '0;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_readies", {61'd0, AWREADY, WREADY, ARREADY}, 64'd0);
    check("rst_valids", {62'd0, BVALID, RVALID}, 64'd0);
    check("rst_payload", {28'd0, BRESP, RRESP, RDATA}, 64'd0);
    ARESET = 1'b0;
    @(negedge clk);
    check("readies_after_rst", {61'd0, AWREADY, WREADY, ARREADY}, 64'd7);

    // Table of single transactions
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_wr) write_word(vecs[i].addr, vecs[i].data, vecs[i].resp);
      else               read_word(vecs[i].addr, vecs[i].data, vecs[i].resp);
    end

    // Split write, AW first; a second AWVALID while AWREADY=0 must be ignored
    AWADDR = 32'd3; AWVALID = 1'b1; WVALID = 1'b0; BREADY = 1'b1;
    wait_ready(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    AWADDR = 32'd8;
    for (int i = 0; i < 3; i++) begin
      check("wait_data_ready", {62'd0, AWREADY, WREADY}, 64'd1);
      check("wait_data_nob", {63'd0, BVALID}, 64'd0);
      @(negedge clk);
    end
    AWVALID = 1'b0; WDATA = 32'h1234; WVALID = 1'b1;
    b_q.push_back(2'b00);
    wait_ready(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    WVALID = 1'b0;
    check("split_aw_b", {63'd0, BVALID}, 64'd1);
    $display("WR split aw-first addr=00000003 data=00001234 bresp=%b", BRESP);
    pop_b("split_aw_bresp");
    @(negedge clk);
    check("split_aw_bdrop", {63'd0, BVALID}, 64'd0);
    read_word(32'd3, 32'h1234, 2'b00);
    read_word(32'd8, 32'h0, 2'b00);

    // Split write, W first; extra WDATA while WREADY=0 must be ignored
    WDATA = 32'h5678; WVALID = 1'b1; AWVALID = 1'b0;
    wait_ready(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    WDATA = 32'h9999;
    for (int i = 0; i < 3; i++) begin
      check("wait_addr_ready", {62'd0, AWREADY, WREADY}, 64'd2);
      check("wait_addr_nob", {63'd0, BVALID}, 64'd0);
      @(negedge clk);
    end
    WVALID = 1'b0; AWADDR = 32'd4; AWVALID = 1'b1;
    b_q.push_back(2'b00);
    wait_ready(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    AWVALID = 1'b0;
    check("split_w_b", {63'd0, BVALID}, 64'd1);
    $display("WR split w-first addr=00000004 data=00005678 bresp=%b", BRESP);
    pop_b("split_w_bresp");
    @(negedge clk);
    check("split_w_bdrop", {63'd0, BVALID}, 64'd0);
    read_word(32'd4, 32'h5678, 2'b00);

    // B backpressure
    AWADDR = 32'd7; WDATA = 32'h77; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    b_q.push_back(2'b00);
    wait_ready(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("b_hold_valid", {63'd0, BVALID}, 64'd1);
      check("b_hold_resp", {62'd0, BRESP}, 64'd0);
      check("b_hold_readies", {62'd0, AWREADY, WREADY}, 64'd0);
      @(negedge clk);
    end
    BREADY = 1'b1;
    $display("WR backpressure addr=00000007 data=00000077 bresp=%b", BRESP);
    pop_b("b_bp_bresp");
    @(negedge clk);
    BREADY = 1'b0;
    check("b_bp_drop", {63'd0, BVALID}, 64'd0);
    check("b_bp_awready", {63'd0, AWREADY}, 64'd1);

    // R backpressure; an AR offered while ARREADY=0 must be ignored
    ARADDR = 32'd7; ARVALID = 1'b1; RREADY = 1'b0;
    r_q.push_back('{resp: 2'b00, data: 32'h77});
    wait_ready(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    ARADDR = 32'd5;
    for (int i = 0; i < 5; i++) begin
      check("r_hold_valid", {63'd0, RVALID}, 64'd1);
      check("r_hold_data", {32'd0, RDATA}, 64'h77);
      check("r_hold_arready", {63'd0, ARREADY}, 64'd0);
      @(negedge clk);
    end
    ARVALID = 1'b0; RREADY = 1'b1;
    $display("RD backpressure addr=00000007 rdata=%08h rresp=%b", RDATA, RRESP);
    pop_r("r_bp_data");
    @(negedge clk);
    RREADY = 1'b0;
    check("r_bp_drop", {63'd0, RVALID}, 64'd0);
    check("r_bp_arready", {63'd0, ARREADY}, 64'd1);

    // Same-edge read and write to index 9: read returns old contents
    AWADDR = 32'd9; WDATA = 32'hA5A5; ARADDR = 32'd9;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
    b_q.push_back(2'b00);
    r_q.push_back('{resp: 2'b00, data: 32'h0});
    check("conc_readies", {61'd0, AWREADY, WREADY, ARREADY}, 64'd7);
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check("conc_valids", {62'd0, BVALID, RVALID}, 64'd3);
    $display("RW concurrent addr=00000009 rdata=%08h bresp=%b", RDATA, BRESP);
    pop_b("conc_bresp");
    pop_r("conc_old_data");
    @(negedge clk);
    read_word(32'd9, 32'hA5A5, 2'b00);

    // Reset with a half-captured write pending
    AWADDR = 32'd2; AWVALID = 1'b1; WVALID = 1'b0;
    wait_ready(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    AWVALID = 1'b0;
    ARESET = 1'b1;
    @(negedge clk);
    ARESET = 1'b0;
    @(negedge clk);
    check("midrst_readies", {61'd0, AWREADY, WREADY, ARREADY}, 64'd7);
    WDATA = 32'h55; WVALID = 1'b1; BREADY = 1'b1;
    wait_ready(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    WVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("midrst_nob", {63'd0, BVALID}, 64'd0);
      @(negedge clk);
    end
    read_word(32'd2, 32'h0, 2'b00);
    AWADDR = 32'd10; AWVALID = 1'b1;
    b_q.push_back(2'b00);
    wait_ready(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    AWVALID = 1'b0;
    check("midrst_fresh_b", {63'd0, BVALID}, 64'd1);
    $display("WR after reset addr=0000000a data=00000055 bresp=%b", BRESP);
    pop_b("midrst_bresp");
    @(negedge clk);
    read_word(32'd10, 32'h55, 2'b00);
    read_word(32'd5, 32'h0, 2'b00);

    check("b_queue_empty", 64'(b_q.size()), 64'd0);
    check("r_queue_empty", 64'(r_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave.md
# axi4_lite_slave

AXI4-Lite slave endpoint with a word-addressed register memory. It sits directly downstream of the AXI4-Lite master on the same bus and is the target of every read and write transaction the master issues. Read and write channels are handled by independent FSMs so that one read and one write can be in flight at the same time. Out-of-range addresses complete the handshake with an error response.

## Interface
Parameters:
- Addr_Width, 32, width of AWADDR/ARADDR
- Data_Width, 32, width of WDATA/RDATA
- Mem_Depth, 64, number of Data_Width words (power of two); IDX = $clog2(Mem_Depth)

Ports (one clock; reset is synchronous and active-high):
- ACLK  in  1  bus clock; everything samples on the rising edge
- ARESET  in  1  synchronous active-high reset
- AWADDR  in  Addr_Width  write address (word index)
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address accepted
- WDATA  in  Data_Width  write data
- WVALID  in  1  write data valid
- WREADY  out  1  write data accepted
- BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- BVALID  out  1  write response valid
- BREADY  in  1  master accepts response
- ARADDR  in  Addr_Width  read address (word index)
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address accepted
- RDATA  out  Data_Width  read data
- RRESP  out  2  read response, same encoding as BRESP
- RVALID  out  1  read data valid
- RREADY  in  1  master accepts data

## Operation
- Address decode: in range when ADDR[Addr_Width-1:IDX] == 0. The index is ADDR[IDX-1:0].
- Write FSM states: WR_IDLE, WR_WAIT_DATA, WR_WAIT_ADDR, WR_RESP.
  - WR_IDLE: AWREADY=1, WREADY=1.
    - AW and W handshake in the same cycle: commit the write and go to WR_RESP.
    - Only AW handshakes: latch the address and go to WR_WAIT_DATA.
    - Only W handshakes: latch the data and go to WR_WAIT_ADDR.
  - WR_WAIT_DATA: AWREADY=0, WREADY=1. On W handshake, commit and go to WR_RESP.
  - WR_WAIT_ADDR: AWREADY=1, WREADY=0. On AW handshake, commit and go to WR_RESP.
  - WR_RESP: AWREADY=WREADY=0, BVALID=1. BRESP=OKAY if the address was in range, otherwise SLVERR. Stay until BREADY=1, then go to WR_IDLE.
  - Commit: mem[idx] <= data only when the address is in range. Out-of-range writes leave memory untouched.
- Read FSM states: RD_IDLE, RD_DATA.
  - RD_IDLE: ARREADY=1. On ARVALID, load RDATA from mem[idx] (or 0 if out of range), load RRESP (OKAY or SLVERR), and go to RD_DATA.
  - RD_DATA: ARREADY=0, RVALID=1. RDATA and RRESP are held stable. Stay until RREADY=1, then go to RD_IDLE.
- The two FSMs are fully independent; neither stalls the other.

## Timing
- Reset values: AWREADY=0, WREADY=0, ARREADY=0, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0. All memory words are cleared to 0. Both FSMs enter their IDLE state.
  - Ready outputs go high in the first cycle after ARESET deasserts.
- Write latency: the memory update happens on the edge where the second of AW/W handshakes. BVALID goes high the following cycle.
- Read latency: with AR handshake at edge N, RVALID and RDATA are valid after edge N, i.e. one cycle later.
- BVALID/RVALID, once high, stay high with stable payload until the ready handshake. They drop on the edge where ready is sampled high.
- Back-to-back: after a B or R handshake, the next AW/W or AR is accepted no earlier than the following cycle (IDLE re-entry).
- Same-edge read and write to the same index: the read returns the old contents (read-before-write).
- VALID without READY: the input is ignored. The FSM must not latch AWADDR or WDATA while the corresponding READY is 0.
- Reset mid-transaction: the FSMs return to IDLE, pending B and R responses are dropped, and any half-captured write is discarded with no memory update.

## Test plan
- Write then read: AW and W together with addr 5, data 32'hDEAD_BEEF, BREADY=1. Expect BVALID one cycle later with BRESP=00. Then AR addr 5 with RREADY=1. Expect RVALID next cycle, RDATA=32'hDEAD_BEEF, RRESP=00.
- Split write: AW addr 3 at cycle 0, W data 32'h1234 at cycle 4. Expect WR_WAIT_DATA during cycles 1-4 with AWREADY=0, BVALID at cycle 5, and a read of addr 3 returning 32'h1234. Repeat with W before AW.
- Response backpressure: write addr 7; hold BREADY=0 for 5 cycles. Expect BVALID held high, BRESP stable, AWREADY=WREADY=0. Raise BREADY: BVALID drops at that edge and AWREADY returns next cycle. Same check for the R channel with RREADY held low.
- Out of range: write addr 64 (Mem_Depth=64) with data 32'hFFFF. Expect BRESP=10. Read addr 64: expect RRESP=10, RDATA=0. A read of addr 0 must still return 0.
- Concurrency: in one cycle, issue AR addr 9 and AW/W to addr 9 with data 32'hA5A5. Expect RDATA = old value (0) and, on a later read of addr 9, 32'hA5A5.
- Reset mid-op: latch AW addr 2, assert ARESET for one cycle, then send W data 32'h55. Expect no BVALID until a fresh AW arrives, and a read of addr 2 returns 0.
